// File: rtl/dram_burst_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dram_arb_pkg
// Shared constants, types and helpers for the two-port DRAM burst arbiter.
//   LINE_W / BEAT_W / BEATS : cache line, DRAM beat and beats-per-line sizes
//   arb_state_t             : arbiter transaction state
//   line_t                  : a cache line viewed as an array of DRAM beats
//   line_align()            : clears the in-line offset bits of an address
// ---------------------------------------------------------------------------
package dram_arb_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        DONE    = 3'd4
    } arb_state_t;

    typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

    // A line spans 32 bytes, so the low five address bits never reach DRAM.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:5], 5'b00000};
    endfunction

endpackage

// File: rtl/dram_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_burst_arbiter_if
// Bundles the cache-side request/response signals and the DRAM burst port.
//   Cache side : req, we, addr0/1, wdata0/1 (in to arbiter); resp, rdata (out)
//   DRAM side  : bmem_addr, bmem_read, bmem_write, bmem_wdata (out);
//                bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid (in)
//   Status     : err (out)
// Modports: slave = arbiter view, master = environment (caches + DRAM) view.
// ---------------------------------------------------------------------------
interface dram_burst_arbiter_if;
    import dram_arb_pkg::*;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [LINE_W-1:0] wdata0;
    logic [LINE_W-1:0] wdata1;
    logic [1:0]        resp;
    logic [LINE_W-1:0] rdata;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
    logic              err;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output resp, rdata, bmem_addr, bmem_read, bmem_write, bmem_wdata, err
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  resp, rdata, bmem_addr, bmem_read, bmem_write, bmem_wdata, err
    );

endinterface

// File: rtl/dram_burst_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Grant is combinational from the requests and
// the priority pointer; the pointer flips on every enabled, non-empty grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req[1:0] : request vector
//   i_en       : grant enable (the grant is being consumed this cycle)
//   o_gnt[1:0] : one-hot grant (zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    // r_ptr = 0 favours port 0 on a tie, 1 favours port 1.
    logic       r_ptr;
    logic [1:0] w_gnt;

    // Pick the winner; a lone requester wins regardless of the pointer.
    always_comb begin
        w_gnt = 2'b00;
        case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    // Priority pointer: flip after every grant that is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_en && (i_req != 2'b00)) begin
            r_ptr <= ~r_ptr;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/dram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// dram_burst_arbiter
// Shares one DRAM burst port between the I-cache (port 0) and D-cache
// (port 1). One whole-line transaction at a time: a read issues a single
// address command and collects four tagged beats; a write streams four beats
// under bmem_ready flow control. Completion is a one-cycle resp pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dram_burst_arbiter_if.slave (cache requests, DRAM port, err)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module dram_burst_arbiter
    import dram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    dram_burst_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    logic [1:0]        r_gnt;
    logic [1:0]        r_cnt;
    logic [1:0]        r_resp;
    line_t             r_line;
    logic [ADDR_W-1:0] r_bmem_addr;
    logic              r_bmem_read;
    logic              r_bmem_write;
    logic [BEAT_W-1:0] r_bmem_wdata;
    logic              r_err;

    logic [1:0]        w_gnt;
    logic              w_arb_en;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    line_t             w_sel_wdata;
    logic              w_beat_hit;
    logic              w_beat_err;

    // Requests are only looked at while idle.
    assign w_arb_en = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.req),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    // Route the winning port's request fields towards the latch.
    always_comb begin
        if (w_gnt[1]) begin
            w_sel_we    = bus.we[1];
            w_sel_addr  = line_align(bus.addr1);
            w_sel_wdata = bus.wdata1;
        end else begin
            w_sel_we    = bus.we[0];
            w_sel_addr  = line_align(bus.addr0);
            w_sel_wdata = bus.wdata0;
        end
    end

    // Classify a returning read beat: accepted only in RD_DATA with a matching
    // tag; anything else (wrong tag, wrong state, late beat) is a protocol error.
    always_comb begin
        w_beat_hit = 1'b0;
        w_beat_err = 1'b0;
        if (bus.bmem_rvalid) begin
            if ((r_state == RD_DATA) && (bus.bmem_raddr == r_bmem_addr)) begin
                w_beat_hit = 1'b1;
            end else begin
                w_beat_err = 1'b1;
            end
        end else begin
            w_beat_hit = 1'b0;
            w_beat_err = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= 2'b00;
            r_cnt        <= 2'd0;
            r_resp       <= 2'b00;
            r_line       <= {LINE_W{1'b0}};
            r_bmem_addr  <= {ADDR_W{1'b0}};
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= {BEAT_W{1'b0}};
            r_err        <= 1'b0;
        end else begin
            if (w_beat_err) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end

            case (r_state)
                IDLE: begin
                    r_resp <= 2'b00;
                    if (w_gnt != 2'b00) begin
                        r_gnt       <= w_gnt;
                        r_bmem_addr <= w_sel_addr;
                        r_cnt       <= 2'd0;
                        if (w_sel_we) begin
                            // The line buffer doubles as the write-data holding register.
                            r_line       <= w_sel_wdata;
                            r_bmem_wdata <= w_sel_wdata[0];
                            r_bmem_write <= 1'b1;
                            r_bmem_read  <= 1'b0;
                            r_state      <= WR_DATA;
                        end else begin
                            r_bmem_read  <= 1'b1;
                            r_bmem_write <= 1'b0;
                            r_state      <= RD_REQ;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end

                RD_REQ: begin
                    if (bus.bmem_ready) begin
                        r_bmem_read <= 1'b0;
                        r_cnt       <= 2'd0;
                        r_state     <= RD_DATA;
                    end else begin
                        r_state <= RD_REQ;
                    end
                end

                RD_DATA: begin
                    if (w_beat_hit) begin
                        r_line[r_cnt] <= bus.bmem_rdata;
                        // Counter wraps 3 -> 0 exactly as the state leaves RD_DATA.
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_resp  <= r_gnt;
                            r_state <= DONE;
                        end else begin
                            r_state <= RD_DATA;
                        end
                    end else begin
                        r_state <= RD_DATA;
                    end
                end

                WR_DATA: begin
                    if (bus.bmem_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_bmem_write <= 1'b0;
                            r_resp       <= r_gnt;
                            r_state      <= DONE;
                        end else begin
                            r_bmem_wdata <= r_line[r_cnt + 2'd1];
                            r_state      <= WR_DATA;
                        end
                    end else begin
                        r_state <= WR_DATA;
                    end
                end

                DONE: begin
                    r_resp  <= 2'b00;
                    r_state <= IDLE;
                end

                default: begin
                    r_resp       <= 2'b00;
                    r_bmem_read  <= 1'b0;
                    r_bmem_write <= 1'b0;
                    r_cnt        <= 2'd0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp       = r_resp;
    assign bus.rdata      = r_line;
    assign bus.bmem_addr  = r_bmem_addr;
    assign bus.bmem_read  = r_bmem_read;
    assign bus.bmem_write = r_bmem_write;
    assign bus.bmem_wdata = r_bmem_wdata;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_dram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_burst_arbiter
// Self-checking bench for dram_burst_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge. Expected completions go into a queue when
// a request is raised and are popped by a monitor whenever resp pulses.
// ---------------------------------------------------------------------------
module tb_dram_burst_arbiter;
    import dram_arb_pkg::*;

    typedef logic [LINE_W-1:0] wide_t;

    typedef struct {
        logic [1:0] resp;
        bit         is_read;
        wide_t      line;
    } sb_t;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [7:0]  rdy_pat;   // bit c = bmem_ready in handshake cycle c
        bit          bad_beat;  // insert a foreign-tag beat before beat 2
        logic [1:0]  exp_resp;
        logic [31:0] exp_baddr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb_q[$];

    dram_burst_arbiter_if bus ();

    dram_burst_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic wide_t rd_line(input logic [31:0] a);
        wide_t l;
        for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = {a, 16'hBEEF, 14'd0, 2'(k)};
        return l;
    endfunction

    function automatic wide_t wr_line(input logic [31:0] a);
        wide_t l;
        for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = {a ^ 32'h5A5A_5A5A, 16'hD00D, 14'd0, 2'(k)};
        return l;
    endfunction

    task automatic drive_req(input int p, input bit w, input logic [31:0] a);
        if (p == 0) begin
            bus.we[0] = w; bus.addr0 = a; bus.wdata0 = wr_line(a); bus.req[0] = 1'b1;
        end else begin
            bus.we[1] = w; bus.addr1 = a; bus.wdata1 = wr_line(a); bus.req[1] = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [31:0] tag, input logic [BEAT_W-1:0] d);
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = tag;
        bus.bmem_rdata  = d;
        tick();
        bus.bmem_rvalid = 1'b0;
    endtask

    // Run one complete transaction for a table vector, checking DRAM-side
    // signalling cycle by cycle and the resp pulse timing.
    task automatic do_txn(input vec_t v);
        wide_t line;
        int    beat;
        int    c;
        bit    rdy;
        line = v.we ? wr_line(v.addr) : rd_line(v.exp_baddr);
        drive_req(v.port, v.we, v.addr);
        sb_q.push_back('{v.exp_resp, !v.we, line});
        tick();
        c = 0;
        beat = 0;
        if (v.we) begin
            while (beat < BEATS && c < 40) begin
                check("wr_valid", wide_t'(bus.bmem_write), wide_t'(1'b1));
                check("wr_addr", wide_t'(bus.bmem_addr), wide_t'(v.exp_baddr));
                check("wr_beat", wide_t'(bus.bmem_wdata), wide_t'(line[beat*BEAT_W +: BEAT_W]));
                rdy = v.rdy_pat[c % 8];
                bus.bmem_ready = rdy;
                tick();
                c++;
                if (rdy) beat++;
            end
            bus.bmem_ready = 1'b0;
            check("wr_done_low", wide_t'(bus.bmem_write), wide_t'(1'b0));
        end else begin
            rdy = 1'b0;
            while (!rdy && c < 40) begin
                check("rd_cmd", wide_t'({bus.bmem_read, bus.bmem_write}), wide_t'(2'b10));
                check("rd_addr", wide_t'(bus.bmem_addr), wide_t'(v.exp_baddr));
                rdy = v.rdy_pat[c % 8];
                bus.bmem_ready = rdy;
                tick();
                c++;
            end
            bus.bmem_ready = 1'b0;
            check("rd_cmd_drop", wide_t'(bus.bmem_read), wide_t'(1'b0));
            for (int k = 0; k < BEATS; k++) begin
                if (v.bad_beat && k == 2) begin
                    send_beat(32'h0000_3000, 64'hDEAD_DEAD_DEAD_DEAD);
                    check("err_set", wide_t'(bus.err), wide_t'(1'b1));
                end
                send_beat(v.exp_baddr, line[k*BEAT_W +: BEAT_W]);
            end
        end
        check("resp_time", wide_t'(bus.resp), wide_t'(v.exp_resp));
        tick();
        check("resp_1cyc", wide_t'(bus.resp), wide_t'(2'b00));
        bus.req[v.port] = 1'b0;
        tick();
    endtask

    // Serve whichever read the arbiter issues next; returns the port it was for.
    task automatic serve_any(output int p);
        int          n;
        logic [31:0] a;
        n = 0;
        while (!bus.bmem_read && n < 20) begin
            tick();
            n++;
        end
        check("cmd_seen", wide_t'(bus.bmem_read), wide_t'(1'b1));
        a = bus.bmem_addr;
        p = (a == 32'h0000_2200) ? 1 : 0;
        bus.bmem_ready = 1'b1;
        tick();
        bus.bmem_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) send_beat(a, {a, 16'hBEEF, 14'd0, 2'(k)});
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every resp pulse must match the oldest expectation.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            check("rd_wr_excl", wide_t'(bus.bmem_read & bus.bmem_write), wide_t'(1'b0));
            if (bus.resp != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("unexp_resp", wide_t'(bus.resp), wide_t'(2'b00));
                end else begin
                    e = sb_q.pop_front();
                    check("sb_resp", wide_t'(bus.resp), wide_t'(e.resp));
                    if (e.is_read) check("sb_rdata", bus.rdata, e.line);
                end
            end
        end
    end

    initial begin
        vec_t tbl[5];
        vec_t vbad;
        int   p;

        rst_n = 1'b0;
        bus.req = 2'b00; bus.we = 2'b00;
        bus.addr0 = 32'd0; bus.addr1 = 32'd0;
        bus.wdata0 = {LINE_W{1'b0}}; bus.wdata1 = {LINE_W{1'b0}};
        bus.bmem_ready = 1'b0; bus.bmem_raddr = 32'd0;
        bus.bmem_rdata = 64'd0; bus.bmem_rvalid = 1'b0;

        tbl[0] = '{0, 1'b0, 32'h0000_1000, 8'hFF, 1'b0, 2'b01, 32'h0000_1000};
        tbl[1] = '{1, 1'b1, 32'h0000_2020, 8'hED, 1'b0, 2'b10, 32'h0000_2020};
        tbl[2] = '{1, 1'b0, 32'h0000_4ABC, 8'hF8, 1'b0, 2'b10, 32'h0000_4AA0};
        tbl[3] = '{0, 1'b1, 32'hFFFF_FFE7, 8'hFF, 1'b0, 2'b01, 32'hFFFF_FFE0};
        tbl[4] = '{0, 1'b0, 32'h8000_0040, 8'hFE, 1'b0, 2'b01, 32'h8000_0040};
        vbad   = '{0, 1'b0, 32'h0000_1000, 8'hFF, 1'b1, 2'b01, 32'h0000_1000};

        // Reset state
        tick();
        tick();
        check("rst_resp", wide_t'(bus.resp), wide_t'(2'b00));
        check("rst_cmd", wide_t'({bus.bmem_read, bus.bmem_write}), wide_t'(2'b00));
        check("rst_err", wide_t'(bus.err), wide_t'(1'b0));
        check("rst_addr", wide_t'(bus.bmem_addr), wide_t'(32'd0));
        check("rst_wdata", wide_t'(bus.bmem_wdata), wide_t'(64'd0));
        check("rst_rdata", bus.rdata, {LINE_W{1'b0}});
        rst_n = 1'b1;
        tick();

        // Table-driven single transactions
        for (int i = 0; i < 5; i++) do_txn(tbl[i]);
        check("err_clean", wide_t'(bus.err), wide_t'(1'b0));

        // Simultaneous reads right after reset: port 0 first, then port 1
        reset_dut();
        drive_req(0, 1'b0, 32'h0000_1100);
        drive_req(1, 1'b0, 32'h0000_2200);
        sb_q.push_back('{2'b01, 1'b1, rd_line(32'h0000_1100)});
        sb_q.push_back('{2'b10, 1'b1, rd_line(32'h0000_2200)});
        serve_any(p);
        check("tie_first", wide_t'(p), wide_t'(0));
        tick(); bus.req[0] = 1'b0; tick();
        serve_any(p);
        check("tie_second", wide_t'(p), wide_t'(1));
        tick(); bus.req[1] = 1'b0; tick();

        // Continuous requests: grants alternate 0,1,0,1
        drive_req(0, 1'b0, 32'h0000_1100);
        drive_req(1, 1'b0, 32'h0000_2200);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb_q.push_back('{2'b01, 1'b1, rd_line(32'h0000_1100)});
            else            sb_q.push_back('{2'b10, 1'b1, rd_line(32'h0000_2200)});
        end
        for (int i = 0; i < 4; i++) begin
            serve_any(p);
            check("rr_order", wide_t'(p), wide_t'(i % 2));
            tick();
            bus.req[p] = 1'b0;
            tick();
            if (i < 2) bus.req[p] = 1'b1;
        end

        // A lone port-0 grant moves the pointer, so the next tie goes to port 1
        do_txn(tbl[0]);
        drive_req(0, 1'b0, 32'h0000_1100);
        drive_req(1, 1'b0, 32'h0000_2200);
        sb_q.push_back('{2'b10, 1'b1, rd_line(32'h0000_2200)});
        sb_q.push_back('{2'b01, 1'b1, rd_line(32'h0000_1100)});
        serve_any(p);
        check("ptr_tie_first", wide_t'(p), wide_t'(1));
        tick(); bus.req[1] = 1'b0; tick();
        serve_any(p);
        check("ptr_tie_second", wide_t'(p), wide_t'(0));
        tick(); bus.req[0] = 1'b0; tick();

        // Foreign-tag beat mid-read: dropped, err sticks, line still correct
        check("err_before", wide_t'(bus.err), wide_t'(1'b0));
        do_txn(vbad);
        tick(); tick();
        check("err_sticky", wide_t'(bus.err), wide_t'(1'b1));

        // Asynchronous reset after two read beats
        drive_req(0, 1'b0, 32'h0000_1000);
        tick();
        bus.bmem_ready = 1'b1; tick(); bus.bmem_ready = 1'b0;
        send_beat(32'h0000_1000, 64'h1111_2222_3333_4444);
        send_beat(32'h0000_1000, 64'h5555_6666_7777_8888);
        rst_n = 1'b0;
        #1;
        check("arst_resp", wide_t'(bus.resp), wide_t'(2'b00));
        check("arst_cmd", wide_t'({bus.bmem_read, bus.bmem_write}), wide_t'(2'b00));
        check("arst_err", wide_t'(bus.err), wide_t'(1'b0));
        check("arst_addr", wide_t'(bus.bmem_addr), wide_t'(32'd0));
        check("arst_wdata", wide_t'(bus.bmem_wdata), wide_t'(64'd0));
        check("arst_rdata", bus.rdata, {LINE_W{1'b0}});
        bus.req = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // A late beat from the abandoned burst flags err
        send_beat(32'h0000_1000, 64'h9999_AAAA_BBBB_CCCC);
        check("late_beat_err", wide_t'(bus.err), wide_t'(1'b1));
        check("late_beat_idle", wide_t'(bus.bmem_read), wide_t'(1'b0));
        // Normal service resumes from IDLE
        do_txn('{1, 1'b0, 32'h0000_5000, 8'hFF, 1'b0, 2'b10, 32'h0000_5000});

        tick();
        check("sb_drained", wide_t'(sb_q.size()), wide_t'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
